// File: rtl/flash_stream_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flash_stream_pkg                                                   |
// | Shared types and constants for the flash stream reader.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package flash_stream_pkg;

  localparam int         FLASH_ADDR_W = 24;
  localparam logic [7:0] ADDR_PAD     = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/flash_stream_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flash_stream_reader_if                                             |
// | Wishbone read-master bus plus the outgoing byte stream.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface flash_stream_reader_if;

  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic        wb_stall;
  logic        wb_ack;
  logic [31:0] wb_dat_miso;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr,
    input  wb_stall, wb_ack, wb_dat_miso,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr,
    output wb_stall, wb_ack, wb_dat_miso,
    input  out_data, out_valid, out_last,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/flash_stream_reader_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_fifo                                                        |
// | First-word fall-through FIFO with synchronous flush.               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stream_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A push into a full FIFO is legal only when a pop frees the slot.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/flash_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | flash_stream_reader                                                |
// | Reads a block of SPI flash over Wishbone and streams it out.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module flash_stream_reader
  import flash_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FLASH_ADDR_W-1:0] src_addr,
  input  logic [LEN_W-1:0]        length,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  flash_stream_reader_if.master   bus
);

  localparam int             TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
  localparam int             CNT_W    = $clog2(FIFO_DEPTH) + 1;

  state_t                  state_q, state_d;
  logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    error_q, error_d;
  logic                    done_q, done_d;
  logic                    gap_q, gap_d;

  logic                    req_go;
  logic                    fifo_push, fifo_pop, fifo_flush;
  logic                    fifo_full, fifo_empty;
  logic [8:0]              fifo_rd;
  logic [CNT_W-1:0]        fifo_count;
  logic                    unused_bits;

  assign unused_bits = ^{bus.wb_dat_miso[31:8], fifo_count};

  stream_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({remaining_q == LEN_W'(1), bus.wb_dat_miso[7:0]}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      error_q     <= error_d;
      done_q      <= done_d;
      gap_q       <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    timer_d     = '0;
    error_d     = error_q;
    done_d      = 1'b0;
    gap_d       = 1'b0;
    fifo_flush  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = src_addr;
            remaining_d = length;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (req_go && !bus.wb_stall) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.wb_ack) begin
          addr_d      = addr_q + FLASH_ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end else begin
            // Forces one cycle with cyc low before the next request.
            state_d = REQ;
            gap_d   = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
          error_d    = 1'b1;
          done_d     = 1'b1;
          fifo_flush = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Only request when the returning byte is guaranteed a FIFO slot.
    req_go        = (state_q == REQ) && !gap_q && !fifo_full;
    fifo_push     = (state_q == WAIT) && bus.wb_ack;
    fifo_pop      = !fifo_empty && bus.out_ready;
    bus.wb_cyc    = req_go || (state_q == WAIT);
    bus.wb_stb    = req_go;
    bus.wb_we     = 1'b0;
    bus.wb_adr    = {ADDR_PAD, addr_q};
    bus.out_valid = !fifo_empty;
    bus.out_data  = fifo_empty ? 8'h00 : fifo_rd[7:0];
    bus.out_last  = !fifo_empty && fifo_rd[8];
    busy          = (state_q != IDLE);
    done          = done_q;
    error         = error_q;
  end

endmodule
`default_nettype wire

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Wishbone master that feeds the SPI flash Wishbone slave (one byte per read transaction, data in dat_miso[7:0]).
- On start, reads LEN consecutive bytes from flash address SRC, buffers them in a small FIFO, and presents them as a valid/ready byte stream with a last flag.
- Used by boot loaders and asset loaders that need bulk flash contents without per-byte bus handling.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.
- LEN_W, 16, width of the length field; max transfer is 2^LEN_W-1 bytes.
- TIMEOUT, 4096, cycles to wait for ack before aborting with error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  pulse; accepted only when busy=0
- src_addr  in  24  first flash byte address, sampled on accepted start
- length  in  LEN_W  byte count, sampled on accepted start
- busy  out  1  transfer in progress, from accepted start until done
- done  out  1  one-cycle pulse at transfer end
- error  out  1  set on timeout; cleared on next accepted start
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  constant 0
- wb_adr  out  32  {8'h00, current 24-bit address}
- wb_stall  in  1  slave stall
- wb_ack  in  1  slave ack
- wb_dat_miso  in  32  read data; only [7:0] is used
- out_data  out  8  stream byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts when valid && ready
- out_last  out  1  marks the final byte of the transfer; qualified by out_valid

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; error=0. Reset mid-transfer drops all state, including the outstanding request. A late ack arriving in IDLE is ignored.
- FSM states:
  - IDLE: on start with length!=0, latch addr=src_addr and remaining=length, clear error, go to REQ. On start with length==0, clear error and pulse done the next cycle; busy stays 0 and there is no bus activity.
  - REQ: enter only if FIFO free slots ≥ 1 (outstanding is always ≤ 1). Assert cyc=stb=1 with adr. A request is accepted in a cycle where stb && !stall; the next cycle stb=0 and the FSM goes to WAIT. stb is held while stall=1.
  - WAIT: cyc=1, stb=0. On ack, push wb_dat_miso[7:0] into the FIFO, drop cyc the next cycle, addr+=1 (24-bit wrap FFFFFF→000000), remaining-=1. If remaining becomes 0 go to DRAIN, else go to REQ (one idle cycle with cyc=0 between transactions). If TIMEOUT!=0 and TIMEOUT cycles elapse without ack: drop cyc, set error, flush FIFO, pulse done, go to IDLE.
  - DRAIN: wait until the FIFO is empty, then pulse done for 1 cycle and go to IDLE.
- busy=1 in every state other than IDLE.
- Back-pressure: if the FIFO is full, the FSM stalls before REQ. A byte is never dropped and never duplicated.
- Stream:
  - out_valid = FIFO non-empty; out_data = FIFO head (first-word fall-through).
  - out_last = 1 when the head is the final byte, tracked by a per-entry last bit written when remaining==1 at push.
- FIFO boundaries:
  - Push and pop in the same cycle while full is legal; count is unchanged.
  - Push while empty makes out_valid=1 the next cycle.
- start while busy=1 is ignored.
- Latency: first byte appears on out_valid 1 cycle after the first ack (0 stall, ideal slave).

Decomposition:
- flash_stream_pkg holds:
  - state_t enum {IDLE, REQ, WAIT, DRAIN};
  - FLASH_ADDR_W=24;
  - the opcode-independent address-pad constant 8'h00.
- One sub-module: stream_fifo (parameterised width/depth, FWFT, full/empty/count). It is instantiated with width 9 to carry {last, byte}.

Test Plan:
- Basic read: start with src=0x000100, len=3; slave returns 0xA1, 0xA2, 0xA3 → adr sequence 0x100, 0x101, 0x102; stream A1, A2, A3; out_last only on A3; done pulse once after the FIFO empties.
- Zero length: start with len=0 → no cyc assertion; done pulses exactly once; busy stays 0.
- Back-pressure: FIFO_DEPTH=4, len=10, out_ready held low → exactly 4 bus reads, then cyc stays low. Release ready → all 10 bytes delivered in order with no gaps or duplicates.
- Stall/wrap: src=0xFFFFFE, len=3, slave stalls 5 cycles per request → stb held through the stall; adr goes FFFFFE, FFFFFF, 000000.
- Timeout: TIMEOUT=16, slave never acks → cyc drops 16 cycles after acceptance; error=1; done pulses; the next start clears error.
- Reset mid-transfer: assert rst during WAIT with 2 bytes buffered → the next cycle all outputs are 0 and the FIFO is empty. A subsequent late ack produces no output byte.
